// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter (CPU MEM stage and debug/loader) onto one synchronous RAM port.
// CPU has priority; a debug request blocked for MAX_WAIT cycles is forced a one-cycle grant.
module dmem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        DBG_FORCE = 1'b1
    } state_t;

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_nxt;
    logic        w_cpu_granted;
    logic        w_dbg_granted;
    logic        r_cpu_pend;
    logic        r_dbg_pend;
    logic [31:0] r_cpu_hold;
    logic [31:0] r_dbg_hold;
    logic [1:0]  w_lane;
    logic [3:0]  w_cpu_we_sh;
    logic [31:0] w_cpu_din_sh;
    logic [3:0]  w_ram_we;
    logic [29:0] w_ram_addr;
    logic [31:0] w_ram_din;

    // Arbitration: grant decode, wait counter and next state from current requests.
    always_comb begin
        w_cpu_granted  = 1'b0;
        w_dbg_granted  = 1'b0;
        w_state_nxt    = CPU_PRI;
        w_wait_cnt_nxt = 4'd0;
        case (r_state)
            CPU_PRI: begin
                w_cpu_granted = cpu_req;
                w_dbg_granted = ~cpu_req & dbg_req;
            end
            DBG_FORCE: begin
                // A dropped debug request simply falls back without touching the RAM.
                w_dbg_granted = dbg_req;
            end
            default: begin
                w_cpu_granted = 1'b0;
                w_dbg_granted = 1'b0;
            end
        endcase
        if (!dbg_req || w_dbg_granted) begin
            w_wait_cnt_nxt = 4'd0;
        end else if (r_wait_cnt != 4'hF) begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end else begin
            w_wait_cnt_nxt = r_wait_cnt;
        end
        if ((r_state == CPU_PRI) && (w_wait_cnt_nxt == C_MAX_WAIT)) begin
            w_state_nxt = DBG_FORCE;
        end else begin
            w_state_nxt = CPU_PRI;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CPU_PRI;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    assign w_lane       = cpu_addr[1:0];
    assign w_cpu_we_sh  = cpu_we << w_lane;
    assign w_cpu_din_sh = cpu_wdata << {w_lane, 3'b000};

    // RAM port mux; everything that can act on the RAM is held off while in reset.
    always_comb begin
        w_ram_we   = 4'd0;
        w_ram_addr = cpu_addr[31:2];
        w_ram_din  = w_cpu_din_sh;
        if (!rst_n) begin
            w_ram_we = 4'd0;
        end else if (w_cpu_granted) begin
            w_ram_we   = w_cpu_we_sh;
            w_ram_addr = cpu_addr[31:2];
            w_ram_din  = w_cpu_din_sh;
        end else if (w_dbg_granted) begin
            w_ram_we   = dbg_we;
            w_ram_addr = dbg_addr[31:2];
            w_ram_din  = dbg_wdata;
        end else begin
            w_ram_we = 4'd0;
        end
    end

    assign ram_we    = w_ram_we;
    assign ram_addr  = w_ram_addr;
    assign ram_din   = w_ram_din;
    assign cpu_stall = rst_n & cpu_req & ~w_cpu_granted;
    assign dbg_gnt   = rst_n & dbg_req & w_dbg_granted;

    // Read-owner tracking and last-value holding for each return channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_pend <= 1'b0;
            r_dbg_pend <= 1'b0;
            r_cpu_hold <= 32'd0;
            r_dbg_hold <= 32'd0;
        end else begin
            r_cpu_pend <= w_cpu_granted & (cpu_we == 4'd0);
            r_dbg_pend <= w_dbg_granted & (dbg_we == 4'd0);
            if (r_cpu_pend) begin
                r_cpu_hold <= ram_dout;
            end
            if (r_dbg_pend) begin
                r_dbg_hold <= ram_dout;
            end
        end
    end

    // RAM data arrives one cycle after the grant, so the return bypasses the hold register.
    assign cpu_rvalid = r_cpu_pend;
    assign dbg_rvalid = r_dbg_pend;
    assign cpu_rdata  = r_cpu_pend ? ram_dout : r_cpu_hold;
    assign dbg_rdata  = r_dbg_pend ? ram_dout : r_dbg_hold;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: port-level checks per cycle plus a read-return scoreboard.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic [3:0]  dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:255];
    logic [31:0] q_cpu [$];
    logic [31:0] q_dbg [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Synchronous RAM model, byte-lane writes, one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_din[8*i +: 8];
        end
        ram_dout <= mem[ram_addr[7:0]];
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        #0;
        mem[8'd8]  <= 32'h1234_5678;
        mem[8'd2]  <= 32'hCAFE_F00D;
        mem[8'd64] <= 32'h1122_3344;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic creq, input logic [3:0] cwe, input logic [31:0] caddr,
                          input logic [31:0] cwd, input logic dreq, input logic [3:0] dwe,
                          input logic [31:0] daddr, input logic [31:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    endtask

    // One cycle: compare grant-side outputs mid-cycle, then move to just after the next edge.
    task automatic step(input string nm, input logic e_stall, input logic e_gnt,
                        input logic [3:0] e_we, input logic [29:0] e_addr,
                        input logic [31:0] e_din, input logic chk_bus);
        @(negedge clk);
        chk({nm, ".cpu_stall"}, 32'(cpu_stall), 32'(e_stall));
        chk({nm, ".dbg_gnt"}, 32'(dbg_gnt), 32'(e_gnt));
        chk({nm, ".ram_we"}, 32'(ram_we), 32'(e_we));
        if (chk_bus) begin
            chk({nm, ".ram_addr"}, 32'(ram_addr), 32'(e_addr));
            chk({nm, ".ram_din"}, ram_din, e_din);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        step("idle", 1'b0, 1'b0, 4'd0, 30'd0, 32'd0, 1'b0);
    endtask

    // Scoreboard monitor: every read return must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cpu_rvalid === 1'b1) begin
                checks++;
                if (q_cpu.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_return: got unexpected rvalid data 0x%08h, expected no return", cpu_rdata);
                end else begin
                    automatic logic [31:0] e = q_cpu.pop_front();
                    if (cpu_rdata !== e) begin
                        errors++;
                        $display("FAIL cpu_return: got 0x%08h, expected 0x%08h", cpu_rdata, e);
                    end
                end
            end
            if (dbg_rvalid === 1'b1) begin
                checks++;
                if (q_dbg.size() == 0) begin
                    errors++;
                    $display("FAIL dbg_return: got unexpected rvalid data 0x%08h, expected no return", dbg_rdata);
                end else begin
                    automatic logic [31:0] e = q_dbg.pop_front();
                    if (dbg_rdata !== e) begin
                        errors++;
                        $display("FAIL dbg_return: got 0x%08h, expected 0x%08h", dbg_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 4'hF, 32'd0, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ram_we", 32'(ram_we), 32'd0);
        chk("rst.cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst.dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst.dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst.cpu_rdata", cpu_rdata, 32'd0);
        chk("rst.dbg_rdata", dbg_rdata, 32'd0);
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unaligned single-byte CPU store into lane 3 of word 0x40.
        set_in(1'b1, 4'b0001, 32'h103, 32'hAB, 1'b0, 4'd0, 32'd0, 32'd0);
        step("store", 1'b0, 1'b0, 4'b1000, 30'h40, 32'hAB00_0000, 1'b1);
        // Debug read-back of the merged word.
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h100, 32'h5A5A_5A5A);
        q_dbg.push_back(32'hAB22_3344);
        step("readback", 1'b0, 1'b1, 4'd0, 30'h40, 32'h5A5A_5A5A, 1'b1);
        idle();

        // CPU load, then rdata must hold once rvalid drops.
        set_in(1'b1, 4'd0, 32'h20, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        q_cpu.push_back(32'h1234_5678);
        step("load", 1'b0, 1'b0, 4'd0, 30'h8, 32'd0, 1'b1);
        idle();
        chk("hold.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("hold.cpu_rdata", cpu_rdata, 32'h1234_5678);

        // Debug read with idle CPU.
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h8, 32'd0);
        q_dbg.push_back(32'hCAFE_F00D);
        step("dbgread", 1'b0, 1'b1, 4'd0, 30'h2, 32'd0, 1'b1);
        idle();

        // Alternating owners on consecutive cycles.
        set_in(1'b1, 4'd0, 32'h20, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        q_cpu.push_back(32'h1234_5678);
        step("alt1", 1'b0, 1'b0, 4'd0, 30'h8, 32'd0, 1'b1);
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h100, 32'd0);
        q_dbg.push_back(32'hAB22_3344);
        step("alt2", 1'b0, 1'b1, 4'd0, 30'h40, 32'd0, 1'b1);
        set_in(1'b1, 4'd0, 32'h8, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        q_cpu.push_back(32'hCAFE_F00D);
        step("alt3", 1'b0, 1'b0, 4'd0, 30'h2, 32'd0, 1'b1);
        idle();
        idle();

        // Starvation: CPU byte writes (no returns) against a pending debug read.
        set_in(1'b1, 4'b0001, 32'h30, 32'h55, 1'b1, 4'd0, 32'h8, 32'd0);
        for (int i = 0; i < 4; i++) step("starve", 1'b0, 1'b0, 4'b0001, 30'hC, 32'h55, 1'b1);
        q_dbg.push_back(32'hCAFE_F00D);
        step("force", 1'b1, 1'b1, 4'd0, 30'h2, 32'd0, 1'b1);
        step("after", 1'b0, 1'b0, 4'b0001, 30'hC, 32'h55, 1'b1);
        idle();

        // Debug request withdrawn while forced: no access, counter restarts.
        set_in(1'b1, 4'b0001, 32'h30, 32'h55, 1'b1, 4'd0, 32'h8, 32'd0);
        for (int i = 0; i < 4; i++) step("pre_drop", 1'b0, 1'b0, 4'b0001, 30'hC, 32'h55, 1'b1);
        dbg_req = 1'b0;
        step("drop", 1'b1, 1'b0, 4'd0, 30'd0, 32'd0, 1'b0);
        dbg_req = 1'b1;
        for (int i = 0; i < 3; i++) step("post_drop", 1'b0, 1'b0, 4'b0001, 30'hC, 32'h55, 1'b1);
        idle();

        // Reset right after a granted CPU read that also arms the forced state.
        set_in(1'b1, 4'd0, 32'h20, 32'd0, 1'b1, 4'd0, 32'h8, 32'd0);
        for (int i = 0; i < 3; i++) begin
            q_cpu.push_back(32'h1234_5678);
            step("pre_rst", 1'b0, 1'b0, 4'd0, 30'h8, 32'd0, 1'b1);
        end
        step("killed_read", 1'b0, 1'b0, 4'd0, 30'h8, 32'd0, 1'b1);
        rst_n = 1'b0;
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("midrst.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("midrst.ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(1'b1, 4'b0001, 32'h30, 32'h55, 1'b1, 4'd0, 32'h8, 32'd0);
        for (int i = 0; i < 4; i++) step("post_rst", 1'b0, 1'b0, 4'b0001, 30'hC, 32'h55, 1'b1);
        q_dbg.push_back(32'hCAFE_F00D);
        step("post_rst_force", 1'b1, 1'b1, 4'd0, 30'h2, 32'd0, 1'b1);
        idle();
        idle();

        chk("cpu_queue_drained", 32'(q_cpu.size()), 32'd0);
        chk("dbg_queue_drained", 32'(q_dbg.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
